// File: rtl/aesl_deadlock_proc_monitor.sv
// Per-process deadlock monitor: flags a sustained stall, then after global detection
// relays the report unit's trace token one waits-for hop per clock.
module aesl_deadlock_proc_monitor #(
  parameter int PROC_NUM     = 4,
  parameter int MY_IDX       = 0,
  parameter int STALL_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                proc_blocked,
  input  logic [PROC_NUM-1:0] dep_vec,
  input  logic                dl_detect_in,
  input  logic [PROC_NUM-1:0] origin,
  input  logic                token_clear,
  input  logic [PROC_NUM-1:0] token_in_vec,
  output logic                dl_out,
  output logic [PROC_NUM-1:0] token_out_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {RUN, SUSPECT, BLOCKED, TRACE} state_e;

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(STALL_CYCLES);
  localparam logic [PROC_NUM-1:0] VEC_ONE  = PROC_NUM'(1);
  localparam logic [PROC_NUM-1:0] SELF     = VEC_ONE << MY_IDX;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               tok_q, tok_d;
  logic               launch_q, launch_d;
  logic               is_origin_q, is_origin_d;

  logic [PROC_NUM-1:0] dep_masked;
  logic [PROC_NUM-1:0] tgt_onehot;
  logic                in_trace;
  logic                fwd;

  // A self-dependence is never a hop; lowest remaining waits-for edge wins.
  always_comb begin
    dep_masked = dep_vec & ~SELF;
    tgt_onehot = dep_masked & (~dep_masked + VEC_ONE);
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    tok_d       = tok_q;
    launch_d    = launch_q;
    is_origin_d = is_origin_q;
    case (state_q)
      RUN: begin
        if (proc_blocked) begin
          state_d     = SUSPECT;
          stall_cnt_d = CNT_ONE;
        end else begin
          stall_cnt_d = '0;
        end
      end
      SUSPECT: begin
        if (!proc_blocked) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end else if (stall_cnt_q == CNT_LAST) begin
          state_d     = BLOCKED;
          stall_cnt_d = CNT_SAT;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
      end
      BLOCKED: begin
        if (!proc_blocked) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end
      end
      TRACE: begin
        tok_d       = |token_in_vec;
        launch_d    = origin[MY_IDX];
        is_origin_d = is_origin_q | origin[MY_IDX];
        if (token_clear) begin
          tok_d       = 1'b0;
          launch_d    = 1'b0;
          is_origin_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    // Global detection overrides any local stall bookkeeping and is sticky.
    if (dl_detect_in) state_d = TRACE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      tok_q       <= 1'b0;
      launch_q    <= 1'b0;
      is_origin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      tok_q       <= tok_d;
      launch_q    <= launch_d;
      is_origin_q <= is_origin_d;
    end
  end

  // The origin absorbs its returning token instead of passing it on again.
  always_comb begin
    in_trace      = (state_q == TRACE);
    fwd           = launch_q | (tok_q & ~is_origin_q);
    dl_out        = in_trace ? tok_q : (state_q == BLOCKED);
    token_out_vec = (in_trace && fwd) ? tgt_onehot : '0;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_aesl_deadlock_proc_monitor.sv
// Bench for four monitors sharing report-unit signals; token paths are either driven
// directly or wired monitor-to-monitor as a ring.
module tb_aesl_deadlock_proc_monitor;
  localparam int N = 4;
  localparam int S = 16;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] blk, origin, dl;
  logic dl_detect, token_clear, ring;
  logic [N-1:0][N-1:0] dep, tin_drv, tin, tout;
  logic [N-1:0][7:0] scnt;
  int n_run = 0;
  int n_fail = 0;
  int mcnt[N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_mon
    for (genvar h = 0; h < N; h++) begin : g_tin
      assign tin[g][h] = ring ? tout[h][g] : tin_drv[g][h];
    end
    aesl_deadlock_proc_monitor #(.PROC_NUM(N), .MY_IDX(g), .STALL_CYCLES(S), .CNT_W(8)) u_mon (
      .clock(clock), .reset(reset), .proc_blocked(blk[g]), .dep_vec(dep[g]),
      .dl_detect_in(dl_detect), .origin(origin), .token_clear(token_clear),
      .token_in_vec(tin[g]), .dl_out(dl[g]), .token_out_vec(tout[g]), .stall_cnt(scnt[g]));
  end

  function automatic int tgt_of(int node);
    for (int j = 0; j < N; j++) if (j != node && dep[node][j]) return j;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int k);
    logic [N-1:0] one = 1;
    return (k < 0) ? '0 : (one << k);
  endfunction

  function automatic logic [N-1:0] tout_all();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r |= tout[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Reference: consecutive blocked edges, capped at the threshold.
  task automatic tick_model();
    for (int i = 0; i < N; i++) mcnt[i] = blk[i] ? ((mcnt[i] < S) ? mcnt[i] + 1 : S) : 0;
    tick();
  endtask

  task automatic init_inputs();
    blk = '0; origin = '0; dl_detect = 1'b0; token_clear = 1'b0; ring = 1'b0;
    dep = '0; tin_drv = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; init_inputs();
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; init_inputs();
    #12;
    n_run++; if (dl !== '0) begin n_fail++; $display("FAIL reset_dl got %b want 0000", dl); end
    n_run++; if (tout_all() !== '0) begin n_fail++; $display("FAIL reset_tok got %b want 0000", tout_all()); end
    for (int i = 0; i < N; i++) begin
      n_run++; if (scnt[i] !== 8'd0) begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d want 0", i, scnt[i]); end
    end
    do_reset();
  endtask

  task automatic test_stall_threshold();
    do_reset();
    blk[0] = 1'b1;
    for (int c = 0; c < S - 1; c++) begin
      tick_model();
      n_run++; if (scnt[0] !== 8'(mcnt[0]) || dl[0] !== 1'b0) begin n_fail++;
        $display("FAIL thr_pre c=%0d got cnt=%0d dl=%b want cnt=%0d dl=0", c, scnt[0], dl[0], mcnt[0]); end
    end
    blk[0] = 1'b0; tick_model();
    n_run++; if (scnt[0] !== 8'd0 || dl[0] !== 1'b0) begin n_fail++;
      $display("FAIL thr_release got cnt=%0d dl=%b want cnt=0 dl=0", scnt[0], dl[0]); end
    blk[0] = 1'b1;
    for (int c = 0; c < S; c++) begin
      tick_model();
      n_run++; if (scnt[0] !== 8'(mcnt[0]) || dl[0] !== (mcnt[0] == S)) begin n_fail++;
        $display("FAIL thr_run c=%0d got cnt=%0d dl=%b want cnt=%0d", c, scnt[0], dl[0], mcnt[0]); end
    end
    n_run++; if (scnt[0] !== 8'd16 || dl[0] !== 1'b1) begin n_fail++;
      $display("FAIL thr_hit got cnt=%0d dl=%b want cnt=16 dl=1", scnt[0], dl[0]); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 300; c++) begin
      tick_model();
      n_run++; if (scnt[0] !== 8'd16 || dl[0] !== 1'b1) begin n_fail++;
        $display("FAIL sat c=%0d got cnt=%0d dl=%b want cnt=16 dl=1", c, scnt[0], dl[0]); end
    end
  endtask

  task automatic test_random_stall();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) blk[i] = ($urandom_range(0, 24) != 0);
      tick_model();
      for (int i = 0; i < N; i++) begin
        n_run++; if (scnt[i] !== 8'(mcnt[i]) || dl[i] !== (mcnt[i] == S)) begin n_fail++;
          $display("FAIL rnd_stall c=%0d m%0d got cnt=%0d dl=%b want cnt=%0d", c, i, scnt[i], dl[i], mcnt[i]); end
      end
    end
  endtask

  task automatic test_origin_launch();
    do_reset();
    dep[1] = 4'b1010; dl_detect = 1'b1;
    tick();
    origin = 4'b0010; tick(); origin = '0;
    n_run++; if (tout[1] !== 4'b1000 || dl !== '0) begin n_fail++;
      $display("FAIL launch got tok=%b dl=%b want tok=1000 dl=0000", tout[1], dl); end
    tick();
    n_run++; if (tout[1] !== 4'b0000 || dl !== '0) begin n_fail++;
      $display("FAIL launch_end got tok=%b dl=%b want tok=0000 dl=0000", tout[1], dl); end
  endtask

  task automatic test_forward_hop();
    logic [N-1:0] deps [3] = '{4'b0001, 4'b0101, 4'b0100};
    logic [N-1:0] want [3] = '{4'b0001, 4'b0001, 4'b0000};
    token_clear = 1'b1; tick(); token_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dep[2] = deps[k]; tin_drv[2] = 4'b0010; tick(); tin_drv[2] = '0;
      n_run++; if (dl[2] !== 1'b1 || tout[2] !== want[k]) begin n_fail++;
        $display("FAIL hop k=%0d got dl=%b tok=%b want dl=1 tok=%b", k, dl[2], tout[2], want[k]); end
      tick();
      n_run++; if (dl[2] !== 1'b0 || tout[2] !== 4'b0000) begin n_fail++;
        $display("FAIL hop_end k=%0d got dl=%b tok=%b want dl=0 tok=0000", k, dl[2], tout[2]); end
    end
    dep[2] = 4'b0110; origin = 4'b0100; tin_drv[2] = 4'b1000; tick();
    origin = '0; tin_drv[2] = '0;
    n_run++; if (dl[2] !== 1'b1 || tout[2] !== 4'b0010) begin n_fail++;
      $display("FAIL launch_and_rx got dl=%b tok=%b want dl=1 tok=0010", dl[2], tout[2]); end
    token_clear = 1'b1; tick(); token_clear = 1'b0;
  endtask

  task automatic test_return_clear();
    dep[1] = 4'b1000; origin = 4'b0010; tick(); origin = '0;
    n_run++; if (dl[1] !== 1'b0 || tout[1] !== 4'b1000) begin n_fail++;
      $display("FAIL ret_launch got dl=%b tok=%b want dl=0 tok=1000", dl[1], tout[1]); end
    tick();
    tin_drv[1] = 4'b1000; tick(); tin_drv[1] = '0;
    n_run++; if (dl[1] !== 1'b1 || tout[1] !== 4'b0000) begin n_fail++;
      $display("FAIL ret_home got dl=%b tok=%b want dl=1 tok=0000", dl[1], tout[1]); end
    token_clear = 1'b1; tick(); token_clear = 1'b0;
    n_run++; if (dl[1] !== 1'b0 || tout[1] !== 4'b0000) begin n_fail++;
      $display("FAIL ret_clear got dl=%b tok=%b want dl=0 tok=0000", dl[1], tout[1]); end
    tin_drv[1] = 4'b1000; tick(); tin_drv[1] = '0;
    n_run++; if (dl[1] !== 1'b1 || tout[1] !== 4'b1000) begin n_fail++;
      $display("FAIL ret_after_clear got dl=%b tok=%b want dl=1 tok=1000", dl[1], tout[1]); end
    tick();
    token_clear = 1'b1; origin = 4'b0010; tin_drv[1] = 4'b0100; tick();
    token_clear = 1'b0; origin = '0; tin_drv[1] = '0;
    n_run++; if (dl[1] !== 1'b0 || tout[1] !== 4'b0000) begin n_fail++;
      $display("FAIL clear_wins got dl=%b tok=%b want dl=0 tok=0000", dl[1], tout[1]); end
    tick();
    n_run++; if (tout_all() !== 4'b0000) begin n_fail++;
      $display("FAIL clear_wins_next got tok=%b want 0000", tout_all()); end
  endtask

  // Graph-level walk: the token follows lowest waits-for edges until it returns home or dies.
  task automatic test_ring_random();
    int o, holder;
    logic [N-1:0] exp_dl, exp_fwd;
    ring = 1'b1;
    for (int t = 0; t < 25; t++) begin
      token_clear = 1'b1; tick(); token_clear = 1'b0;
      for (int i = 0; i < N; i++) dep[i] = 4'($urandom_range(0, 15));
      o = int'($urandom_range(0, N - 1));
      origin = oh(o); tick(); origin = '0;
      n_run++; if (dl !== '0 || tout_all() !== oh(tgt_of(o))) begin n_fail++;
        $display("FAIL ring_launch t=%0d got dl=%b tok=%b want dl=0000 tok=%b", t, dl, tout_all(), oh(tgt_of(o))); end
      holder = tgt_of(o);
      for (int k = 1; k <= 10; k++) begin
        tick();
        exp_dl  = oh(holder);
        exp_fwd = (holder >= 0 && holder != o) ? oh(tgt_of(holder)) : '0;
        n_run++; if (dl !== exp_dl || tout_all() !== exp_fwd) begin n_fail++;
          $display("FAIL ring t=%0d k=%0d got dl=%b tok=%b want dl=%b tok=%b", t, k, dl, tout_all(), exp_dl, exp_fwd); end
        holder = (holder < 0 || holder == o) ? -1 : tgt_of(holder);
      end
      token_clear = 1'b1; tick(); token_clear = 1'b0;
      n_run++; if (dl !== '0 || tout_all() !== '0) begin n_fail++;
        $display("FAIL ring_clear t=%0d got dl=%b tok=%b want 0000", t, dl, tout_all()); end
    end
    ring = 1'b0;
  endtask

  task automatic test_async_reset();
    token_clear = 1'b1; tick(); token_clear = 1'b0;
    dep[2] = 4'b0001; tin_drv[2] = 4'b0010; tick(); tin_drv[2] = '0;
    n_run++; if (dl[2] !== 1'b1 || tout[2] !== 4'b0001) begin n_fail++;
      $display("FAIL ar_hold got dl=%b tok=%b want dl=1 tok=0001", dl[2], tout[2]); end
    #2 reset = 1'b0;
    #1;
    n_run++; if (dl !== '0 || tout_all() !== '0) begin n_fail++;
      $display("FAIL ar_async got dl=%b tok=%b want 0000", dl, tout_all()); end
    init_inputs(); tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_run++; if (scnt[i] !== 8'd0) begin n_fail++; $display("FAIL ar_cnt[%0d] got %0d want 0", i, scnt[i]); end
    end
    blk[2] = 1'b1; tick();
    n_run++; if (scnt[2] !== 8'd1 || dl !== '0) begin n_fail++;
      $display("FAIL ar_run got cnt=%0d dl=%b want cnt=1 dl=0000", scnt[2], dl); end
  endtask

  initial begin
    test_reset();
    test_stall_threshold();
    test_saturation();
    test_random_stall();
    test_origin_launch();
    test_forward_hop();
    test_return_clear();
    test_ring_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/aesl_deadlock_proc_monitor.md
Name: aesl_deadlock_proc_monitor

Overview:
- Per-process deadlock monitor for the cosim testbench, one instance per dataflow process. Together the instances drive the deadlock report unit's dl_in_vec and consume its outputs.
- Before detection: flags its process as deadlock-suspect after a sustained stall.
- After global detection: takes part in a token walk along waits-for edges, so the report unit can trace each dependence cycle one hop per clock.

Parameters:
PROC_NUM, 4, number of monitored processes (width of all vectors)
MY_IDX, 0, index of this monitor's bit in all vectors (0..PROC_NUM-1)
STALL_CYCLES, 16, consecutive blocked cycles before suspect flag (>=2, <2^CNT_W)
CNT_W, 8, stall counter width

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
proc_blocked  in  1  process is stalled on a channel this cycle
dep_vec  in  PROC_NUM  processes this one is waiting on (bit j = waits on j)
dl_detect_in  in  1  global deadlock-detected level from the report unit
origin  in  PROC_NUM  one-cycle one-hot cycle-start select from the report unit
token_clear  in  1  report unit: current cycle trace complete
token_in_vec  in  PROC_NUM  token arriving; bit j = monitor j passes to me (OR of peers)
dl_out  out  1  this process's bit of dl_in_vec
token_out_vec  out  PROC_NUM  one-hot token pass to the target monitor
stall_cnt  out  CNT_W  current consecutive-stall count (debug)

Behaviour:
- Reset (reset=0, async): state=RUN, stall_cnt=0, tok_q=0, launch_q=0, is_origin_q=0. All outputs are 0.
- States: RUN, SUSPECT, BLOCKED, TRACE. TRACE has top priority: any state moves to TRACE at the edge where dl_detect_in=1. TRACE is left only by reset.
- RUN:
  - proc_blocked=1 -> SUSPECT, stall_cnt=1.
  - Otherwise stay in RUN, stall_cnt=0.
- SUSPECT:
  - proc_blocked=0 -> RUN, stall_cnt=0.
  - proc_blocked=1 and stall_cnt==STALL_CYCLES-1 -> BLOCKED, stall_cnt=STALL_CYCLES.
  - Otherwise stall_cnt+1.
- BLOCKED:
  - proc_blocked=0 -> RUN, stall_cnt=0.
  - Otherwise hold (stall_cnt saturates, never wraps).
- dl_out outside TRACE: 1 iff state==BLOCKED (registered). Net effect: dl_out rises after exactly STALL_CYCLES consecutive blocked edges.
- Target: tgt = lowest set bit of dep_vec with bit MY_IDX masked. If no bit remains, there is no target and the token is dropped.
- TRACE edge updates:
  - tok_q <= |token_in_vec.
  - launch_q <= origin[MY_IDX].
  - is_origin_q is set by origin[MY_IDX] and held until token_clear.
  - tok_q and launch_q are single-cycle pulses.
- TRACE combinational outputs:
  - dl_out = tok_q.
  - token_out_vec = onehot(tgt) when launch_q, or when (tok_q & ~is_origin_q); otherwise 0.
  - Net effect: the origin launches without asserting dl_out. Each hop asserts dl_out for exactly one cycle and forwards in that same cycle. When the token returns to the origin, dl_out=1 and there is no forward.
- Hop latency: one clock per hop. Token leaves the origin on cycle T+1 after origin pulses on cycle T. The first hop's dl_out is high on T+2.
- token_clear=1 at an edge: tok_q, launch_q and is_origin_q all clear. Clear wins over a simultaneous token_in_vec or origin.
- Simultaneous token_in_vec bits are ORed (single token assumed).
- Token received while launch_q=1: both take effect; the forward is still a single onehot(tgt).
- Reset mid-trace: everything returns to the reset values immediately. dl_out=0 asynchronously.

Test Plan:
- Stall threshold: proc_blocked=1 for 15 edges, then 0 -> dl_out stays 0 and stall_cnt returns to 0. Then 16 consecutive blocked edges -> dl_out=1 after edge 16, stall_cnt=16.
- Saturation: STALL_CYCLES=16, proc_blocked held for 300 cycles -> stall_cnt stays at 16, dl_out stays 1.
- Origin launch: MY_IDX=1, dl_detect_in=1, dep_vec=4'b1010, origin=4'b0010 for one cycle -> token_out_vec=4'b1000 for one cycle, dl_out stays 0.
- Forward hop: MY_IDX=2, TRACE, dep_vec=4'b0001, token_in_vec=4'b0010 pulse -> next cycle dl_out=1 and token_out_vec=4'b0001 for exactly one cycle.
- Return and clear: origin monitor receives the token back -> dl_out=1 with token_out_vec=0. token_clear in the same cycle -> is_origin_q cleared; a later token arrival forwards normally.
- Async reset in TRACE while holding the token -> dl_out and token_out_vec drop before the next clock edge. After release, state=RUN and stall_cnt=0.
